// File: rtl/rng_arbiter_if.sv
// Requester and rng-side signal bundle for rng_arbiter.
// slave = the arbiter itself, master = whatever drives requests and models the rng.
interface rng_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int C_RNG_SIZE = 32
);
  logic [N_REQ-1:0]      req;
  logic [N_REQ-1:0]      ack;
  logic [C_RNG_SIZE-1:0] result;
  logic                  err;
  logic                  busy;
  logic                  rng_start;
  logic [C_RNG_SIZE-1:0] rng_result;
  logic                  rng_valid;
  logic [1:0]            dbg_state;

  // req is a level held until its one-cycle ack pulse; rng_start is a one-cycle
  // pulse and rng_valid qualifies rng_result for exactly the cycles it is high.
  modport slave (
    input  req, rng_result, rng_valid,
    output ack, result, err, busy, rng_start, dbg_state
  );

  modport master (
    output req, rng_result, rng_valid,
    input  ack, result, err, busy, rng_start, dbg_state
  );
endinterface

// File: rtl/rng_arbiter.sv
// Round-robin sharing of one rng between N_REQ requesters, with a watchdog that
// turns a stuck rng into an err completion. Define RNG_CACHE_EN for a one-word prefetch cache.
module rng_arbiter #(
  parameter int N_REQ      = 4,
  parameter int C_RNG_SIZE = 32,
  parameter int C_TIMEOUT  = 1024
) (
  input  logic          clk,
  input  logic          resetn,
  rng_arbiter_if.slave  bus
);
  localparam int PW = $clog2(N_REQ);
  localparam int WW = $clog2(C_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DONE  = 2'd2,
    S_SERVE = 2'd3
  } state_t;

  state_t                state;
  logic [PW-1:0]         rr_ptr;
  logic [PW-1:0]         grant;
  logic [WW-1:0]         wd_cnt;
  logic [N_REQ-1:0]      ack;
  logic [C_RNG_SIZE-1:0] result;
  logic                  err;
  logic                  busy;
  logic                  rng_start;
  logic                  refill;

  logic [PW-1:0]         pick;
  logic                  any_req;
  logic                  timeout;
  logic [N_REQ-1:0]      grant_onehot;

`ifdef RNG_CACHE_EN
  logic [C_RNG_SIZE-1:0] cache;
  logic                  cache_valid;
  logic                  need_refill;
`else
  assign refill = 1'b0;
`endif

  // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
  always_comb begin
    pick = rr_ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.req[PW'((int'(rr_ptr) + k) % N_REQ)]) pick = PW'((int'(rr_ptr) + k) % N_REQ);
    end
  end

  assign any_req      = |bus.req;
  assign timeout      = (wd_cnt == WW'(C_TIMEOUT - 1));
  assign grant_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << grant;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      wd_cnt    <= '0;
      ack       <= '0;
      result    <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      rng_start <= 1'b0;
`ifdef RNG_CACHE_EN
      refill      <= 1'b0;
      cache       <= '0;
      cache_valid <= 1'b0;
      need_refill <= 1'b1;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            grant <= pick;
            busy  <= 1'b1;
`ifdef RNG_CACHE_EN
            refill <= 1'b0;
            if (cache_valid) begin
              state <= S_SERVE;
            end else begin
              rng_start <= 1'b1;
              state     <= S_WAIT;
            end
          end else if (need_refill) begin
            need_refill <= 1'b0;
            refill      <= 1'b1;
            busy        <= 1'b1;
            rng_start   <= 1'b1;
            state       <= S_WAIT;
`else
            rng_start <= 1'b1;
            state     <= S_WAIT;
`endif
          end
        end

        S_WAIT: begin
          rng_start <= 1'b0;
          wd_cnt    <= wd_cnt + 1'b1;
          if (bus.rng_valid || timeout) begin
            if (refill) begin
              // A refill completes silently; a timed-out refill just leaves the cache empty.
`ifdef RNG_CACHE_EN
              if (bus.rng_valid) begin
                cache       <= bus.rng_result;
                cache_valid <= 1'b1;
              end
`endif
              wd_cnt <= '0;
              busy   <= 1'b0;
              state  <= S_IDLE;
            end else begin
              result <= bus.rng_valid ? bus.rng_result : '0;
              err    <= ~bus.rng_valid;
              ack    <= grant_onehot;
              state  <= S_DONE;
            end
          end
        end

        S_SERVE: begin
`ifdef RNG_CACHE_EN
          result      <= cache;
          cache_valid <= 1'b0;
          need_refill <= 1'b1;
`endif
          err   <= 1'b0;
          ack   <= grant_onehot;
          state <= S_DONE;
        end

        S_DONE: begin
          ack    <= '0;
          err    <= 1'b0;
          wd_cnt <= '0;
          rr_ptr <= (grant == PW'(N_REQ - 1)) ? '0 : grant + 1'b1;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ack       = ack;
  assign bus.result    = result;
  assign bus.err       = err;
  assign bus.busy      = busy;
  assign bus.rng_start = rng_start;
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_rng_arbiter.sv
// Directed-plus-random bench for rng_arbiter with an rng model and a
// round-robin reference model; build with +define+RNG_CACHE_EN for the cache sequence.
module tb_rng_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  localparam int T = 32;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  rng_arbiter_if #(.N_REQ(N), .C_RNG_SIZE(W)) bus ();

  rng_arbiter #(.N_REQ(N), .C_RNG_SIZE(W), .C_TIMEOUT(T)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // rng model: rng_delay cycles after seeing rng_start it presents one word
  // (0 = never answers). Delivered words go to the expected queue.
  int          rng_delay = 1;
  int          rng_cnt = -1;
  int          starts = 0;
  logic [W-1:0] word_q[$];
  logic [W-1:0] exp_q[$];

  initial begin
    bus.req        = '0;
    bus.rng_valid  = 1'b0;
    bus.rng_result = '0;
  end

  always @(negedge clk) begin
    bus.rng_valid = 1'b0;
    if (rng_cnt > 0) begin
      rng_cnt--;
      if (rng_cnt == 0) begin
        bus.rng_valid  = 1'b1;
        bus.rng_result = (word_q.size() > 0) ? word_q.pop_front() : W'($urandom);
        exp_q.push_back(bus.rng_result);
        rng_cnt = -1;
      end
    end
    if (!resetn && bus.rng_start) begin
      starts++;
      rng_cnt = (rng_delay > 0) ? rng_delay : -1;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: observed simulation still running, expected finish");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ack(input int limit, output int cycles, output logic seen);
    seen = 1'b0;
    cycles = 0;
    while (!seen && cycles < limit) begin
      step(1);
      cycles++;
      if (bus.ack != '0) seen = 1'b1;
    end
  endtask

  task automatic do_reset();
    bus.req = '0;
    resetn = 1'b1;
    step(12);
    exp_q.delete();
    word_q.delete();
    resetn = 1'b0;
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] pop_exp();
    logic [W-1:0] v;
    v = 'x;
    if (exp_q.size() > 0) v = exp_q.pop_front();
    return v;
  endfunction

  initial begin : main
    int           ptr;
    int           g;
    int           cycles;
    int           s0;
    int           ack_count;
    logic         seen;
    logic [N-1:0] req_model;
    logic [N-1:0] one;

    // Reset values
    step(2);
    check("rst_ack", bus.ack, 0);
    check("rst_result", bus.result, 0);
    check("rst_err", bus.err, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_start", bus.rng_start, 0);
    do_reset();
    ptr = 0;

`ifdef RNG_CACHE_EN
    // Prefill after reset, then a cache hit answers two cycles after req.
    rng_delay = 3;
    s0 = starts;
    step(10);
    check("prefill_starts", starts - s0, 1);
    check("prefill_no_ack", bus.ack, 0);
    check("prefill_busy", bus.busy, 0);
    bus.req = 4'b0001;
    wait_ack(10, cycles, seen);
    check("hit_seen", seen, 1);
    check("hit_latency", cycles, 2);
    check("hit_ack", bus.ack, 4'b0001);
    check("hit_result", bus.result, pop_exp());
    check("hit_err", bus.err, 0);
    bus.req = '0;
    step(6);
    check("refill_starts", starts - s0, 2);
    check("refill_no_ack", bus.ack, 0);
`else
    // Single uncontended request with a fixed word
    word_q.push_back(32'hDEADBEEF);
    rng_delay = 5;
    s0 = starts;
    bus.req = 4'b0010;
    wait_ack(40, cycles, seen);
    check("basic_seen", seen, 1);
    check("basic_latency", cycles, rng_delay + 2);
    check("basic_ack", bus.ack, 4'b0010);
    check("basic_result", bus.result, 32'hDEADBEEF);
    check("basic_err", bus.err, 0);
    void'(pop_exp());
    bus.req = '0;
    step(1);
    check("basic_ack_drop", bus.ack, 0);
    check("basic_busy_low", bus.busy, 0);
    check("basic_result_hold", bus.result, 32'hDEADBEEF);
    check("basic_starts", starts - s0, 1);

    // All four held from reset: grants rotate 0,1,2,3
    do_reset();
    ptr = 0;
    req_model = 4'b1111;
    bus.req = req_model;
    for (int i = 0; i < N; i++) begin
      rng_delay = $urandom_range(1, 8);
      g = rr_pick(req_model, ptr);
      one = 4'b0001 << g;
      wait_ack(40, cycles, seen);
      check("fair_seen", seen, 1);
      check("fair_order", g, i);
      check("fair_ack", bus.ack, one);
      check("fair_result", bus.result, pop_exp());
      req_model[g] = 1'b0;
      bus.req = req_model;
      ptr = (g + 1) % N;
    end

    // Random request arrivals against the round-robin model
    for (int i = 0; i < 16; i++) begin
      req_model = req_model | N'($urandom_range(0, 15));
      if (req_model == '0) req_model = 4'b0001;
      rng_delay = $urandom_range(1, 8);
      bus.req = req_model;
      g = rr_pick(req_model, ptr);
      one = 4'b0001 << g;
      wait_ack(40, cycles, seen);
      check("rand_seen", seen, 1);
      check("rand_ack", bus.ack, one);
      check("rand_result", bus.result, pop_exp());
      check("rand_err", bus.err, 0);
      req_model[g] = 1'b0;
      bus.req = req_model;
      ptr = (g + 1) % N;
    end
    req_model = '0;
    bus.req = '0;
    step(12);
    exp_q.delete();

    // Stuck rng: watchdog completion after C_TIMEOUT WAIT cycles
    rng_delay = 0;
    req_model = 4'b0001;
    bus.req = req_model;
    g = rr_pick(req_model, ptr);
    one = 4'b0001 << g;
    wait_ack(T + 20, cycles, seen);
    check("to_seen", seen, 1);
    check("to_latency", cycles, T + 1);
    check("to_ack", bus.ack, one);
    check("to_err", bus.err, 1);
    check("to_result", bus.result, 0);
    bus.req = '0;
    ptr = (g + 1) % N;
    step(2);

    // Normal service after a timeout
    rng_delay = 3;
    req_model = 4'b0100;
    bus.req = req_model;
    wait_ack(40, cycles, seen);
    check("post_to_ack", bus.ack, 4'b0100);
    check("post_to_err", bus.err, 0);
    check("post_to_result", bus.result, pop_exp());
    bus.req = '0;
    ptr = 3;
    step(2);

    // Valid on the exact timeout cycle wins
    rng_delay = T - 1;
    bus.req = 4'b1000;
    wait_ack(T + 20, cycles, seen);
    check("edge_latency", cycles, T + 1);
    check("edge_ack", bus.ack, 4'b1000);
    check("edge_err", bus.err, 0);
    check("edge_result", bus.result, pop_exp());
    bus.req = '0;
    step(2);

    // Valid one cycle too late: timeout, and the late word (arriving in DONE) is ignored
    rng_delay = T;
    bus.req = 4'b0001;
    wait_ack(T + 20, cycles, seen);
    check("late_ack", bus.ack, 4'b0001);
    check("late_err", bus.err, 1);
    check("late_result", bus.result, 0);
    bus.req = '0;
    step(1);
    check("late_ack_drop", bus.ack, 0);
    check("late_result_hold", bus.result, 0);
    step(2);
    exp_q.delete();

    // Reset in the middle of WAIT
    rng_delay = 3;
    bus.req = 4'b0010;
    wait_ack(40, cycles, seen);
    void'(pop_exp());
    bus.req = '0;
    step(2);
    rng_delay = 6;
    bus.req = 4'b0001;
    step(3);
    resetn = 1'b1;
    #1;
    check("midrst_ack", bus.ack, 0);
    check("midrst_result", bus.result, 0);
    check("midrst_err", bus.err, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_start", bus.rng_start, 0);
    bus.req = '0;
    step(1);
    resetn = 1'b0;
    ack_count = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (bus.ack != '0) ack_count++;
    end
    check("midrst_no_ack", ack_count, 0);
    check("midrst_idle", bus.busy, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
